// File: rtl/led_fader.sv
// Eight-channel LED driver: captured on/off pattern with PWM dimming and a
// timed linear fade-out for LEDs that switch off.
module led_fader #(
    parameter int unsigned FADE_DIV  = 250_000,
    parameter int unsigned FADE_STEP = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pattern_in,
    input  logic       pattern_valid,
    input  logic       enable,
    output logic [7:0] leds_pwm,
    output logic       fading
);

    localparam int unsigned   PW        = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(FADE_DIV - 1);
    localparam logic [7:0]    STEP      = 8'(FADE_STEP);
    localparam logic [7:0]    PWM_MAX   = 8'd254;

    logic [7:0]    r_pat;
    logic [7:0]    r_lvl [8];
    logic [7:0]    r_pwm_cnt;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_leds;
    logic          r_fading;

    logic          w_tick;
    logic [7:0]    w_eff;
    logic [7:0]    w_lvl_nxt [8];
    logic [7:0]    w_pwm_bits;
    logic          w_fade_any;

    always_comb begin
        w_tick     = (r_presc == PRESC_MAX);
        w_eff      = pattern_valid ? pattern_in : r_pat;
        w_pwm_bits = '0;
        w_fade_any = 1'b0;
        w_lvl_nxt  = '{default: '0};
        for (int unsigned i = 0; i < 8; i++) begin
            w_pwm_bits[i] = enable & (r_pwm_cnt < r_lvl[i]);
            w_fade_any    = w_fade_any | (~r_pat[i] & (r_lvl[i] != 8'd0));
            // A lit bit wins over a tick; a dark bit decays from its pre-edge level.
            if (w_eff[i])
                w_lvl_nxt[i] = 8'hFF;
            else if (w_tick)
                w_lvl_nxt[i] = (r_lvl[i] > STEP) ? (r_lvl[i] - STEP) : '0;
            else
                w_lvl_nxt[i] = r_lvl[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat     <= '0;
            r_lvl     <= '{default: '0};
            r_pwm_cnt <= '0;
            r_presc   <= '0;
            r_leds    <= '0;
            r_fading  <= 1'b0;
        end else begin
            r_pat     <= w_eff;
            r_lvl     <= w_lvl_nxt;
            r_pwm_cnt <= (r_pwm_cnt == PWM_MAX) ? '0 : r_pwm_cnt + 8'd1;
            r_presc   <= w_tick ? '0 : r_presc + PW'(1);
            r_leds    <= w_pwm_bits;
            r_fading  <= w_fade_any;
        end
    end

    assign leds_pwm = r_leds;
    assign fading   = r_fading;

endmodule

// File: tb/tb_led_fader.sv
// Randomized bench for led_fader: two instances (step 64 and step 200) checked
// every cycle against a cycle-count based model, plus literal pins.
module tb_led_fader;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pin = '0;
    logic       pv  = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] leds1, leds2;
    logic       fad1, fad2;

    led_fader #(.FADE_DIV(DIV), .FADE_STEP(64)) u_dut (
        .clk(clk), .rst(rst), .pattern_in(pin), .pattern_valid(pv),
        .enable(en), .leds_pwm(leds1), .fading(fad1)
    );

    led_fader #(.FADE_DIV(DIV), .FADE_STEP(200)) u_dut200 (
        .clk(clk), .rst(rst), .pattern_in(pin), .pattern_valid(pv),
        .enable(en), .leds_pwm(leds2), .fading(fad2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: time since reset release gives the PWM phase and tick instants directly.
    logic [7:0] m_pat = '0;
    int         m_n   = 0;
    int         m_lvl [2][8];
    logic [7:0] e_leds [2] = '{8'h00, 8'h00};
    logic       e_fad  [2] = '{1'b0, 1'b0};
    int         steps  [2] = '{64, 200};

    always @(posedge clk or posedge rst) begin : mdl
        logic [7:0] eff;
        bit         tick;
        if (rst) begin
            m_pat = '0;
            m_n   = 0;
            for (int k = 0; k < 2; k++) begin
                e_leds[k] = '0;
                e_fad[k]  = 1'b0;
                for (int i = 0; i < 8; i++) m_lvl[k][i] = 0;
            end
        end else begin
            tick = ((m_n % DIV) == DIV - 1);
            eff  = pv ? pin : m_pat;
            for (int k = 0; k < 2; k++) begin
                e_leds[k] = '0;
                e_fad[k]  = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    e_leds[k][i] = en && ((m_n % 255) < m_lvl[k][i]);
                    if (!m_pat[i] && m_lvl[k][i] != 0) e_fad[k] = 1'b1;
                    if (eff[i])    m_lvl[k][i] = 255;
                    else if (tick) m_lvl[k][i] = (m_lvl[k][i] > steps[k]) ? m_lvl[k][i] - steps[k] : 0;
                end
            end
            m_pat = eff;
            m_n++;
        end
    end

    always @(negedge clk) begin
        chk("leds_pwm",     leds1, e_leds[0]);
        chk("fading",       fad1,  e_fad[0]);
        chk("leds_pwm_s200", leds2, e_leds[1]);
        chk("fading_s200",  fad2,  e_fad[1]);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int q[$];
    int prev;
    int exp27[4] = '{191, 127, 63, 0};
    int exp29[2] = '{55, 0};

    initial begin
        // Reset held with inputs toggling.
        repeat (10) begin
            step(1);
            pin = 8'($urandom);
            pv  = 1'($urandom);
            en  = 1'($urandom);
        end
        pin = '0; pv = 1'b0; en = 1'b1;
        step(1);
        rst = 1'b0;
        step(6);
        chk("idle_leds", leds1, 8'h00);
        chk("idle_fad",  fad1,  1'b0);

        // Light five LEDs.
        pin = 8'h1F; pv = 1'b1;
        step(1);
        pv = 1'b0;
        chk("mdl_lvl4_lit", m_lvl[0][4], 255);
        chk("mdl_lvl5_dark", m_lvl[0][5], 0);
        step(3);
        chk("lit_1F", leds1, 8'h1F);
        chk("lit_1F_fad", fad1, 1'b0);

        // LED0 switches off and fades in four ticks.
        pin = 8'h3E; pv = 1'b1;
        step(1);
        pv = 1'b0;
        q.delete(); prev = 255;
        for (int c = 0; c < 20; c++) begin
            if (m_lvl[0][0] != prev) begin
                q.push_back(m_lvl[0][0]);
                prev = m_lvl[0][0];
            end
            step(1);
        end
        chk("fade_seq_len", q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("fade_seq", (i < q.size()) ? q[i] : -1, exp27[i]);
        chk("fade_done", fad1, 1'b0);

        // Pattern strobe coincident with a tick.
        pin = 8'h01; pv = 1'b1;
        step(1);
        pv = 1'b0;
        step(2);
        for (int c = 0; c < 8 && (m_n % DIV) != DIV - 1; c++) step(1);
        chk("coinc_align", m_n % DIV, DIV - 1);
        pin = 8'h02; pv = 1'b1;
        step(1);
        pv = 1'b0;
        chk("coinc_lvl1", m_lvl[0][1], 255);
        chk("coinc_lvl0", m_lvl[0][0], 191);
        chk("coinc_lvl0_s200", m_lvl[1][0], 55);

        // Large step saturates at zero.
        pin = 8'h00; pv = 1'b1;
        step(1);
        pv = 1'b0;
        q.delete(); prev = 255;
        for (int c = 0; c < 16; c++) begin
            if (m_lvl[1][1] != prev) begin
                q.push_back(m_lvl[1][1]);
                prev = m_lvl[1][1];
            end
            step(1);
        end
        chk("s200_seq_len", q.size(), 2);
        for (int i = 0; i < 2; i++)
            chk("s200_seq", (i < q.size()) ? q[i] : -1, exp29[i]);
        chk("s200_fad_done", fad2, 1'b0);

        // Enable low for 100 cycles mid-fade.
        pin = 8'hFF; pv = 1'b1;
        step(1);
        pin = 8'h0F;
        step(1);
        pv = 1'b0;
        step(3);
        en = 1'b0;
        step(50);
        chk("en_low_leds", leds1, 8'h00);
        step(50);
        en = 1'b1;
        step(60);

        // Reset pulse mid-fade.
        pin = 8'hFF; pv = 1'b1;
        step(1);
        pin = 8'h00;
        step(1);
        pv = 1'b0;
        step(3);
        rst = 1'b1;
        #1;
        chk("rst_leds", leds1, 8'h00);
        chk("rst_fad",  fad1,  1'b0);
        chk("rst_mdl_lvl", m_lvl[0][0], 0);
        step(2);
        rst = 1'b0;
        step(5);
        chk("post_rst_leds", leds1, 8'h00);

        // Random traffic.
        repeat (3000) begin
            pv  = ($urandom_range(0, 9) == 0);
            pin = 8'($urandom);
            if ($urandom_range(0, 49) == 0) en = ~en;
            step(1);
        end
        pv = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
